rtc_transaction_sequencer: RTL and testbench

//  Sequences bus transactions on the RTC control-signal generator (en_funcion / in_escribir_leer / flag_done).

---
 rtl/rtc_transaction_sequencer.sv | 249 ++++++++++++++++++++++++
 tb/tb_rtc_transaction_sequencer.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_transaction_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : rtc_transaction_sequencer
// Description : Drives the RTC control-signal generator. After reset it issues
//               one configuration write, then periodically sweeps N_REGS
//               consecutive RTC registers into a shadow bank that is committed
//               atomically to time_bank. User writes are slotted in only while
//               idle between sweeps; a sweep follows every user write.
// Revision    : 1.0 - initial release
// ============================================================================
module rtc_transaction_sequencer #(
    parameter int          N_REGS    = 4,
    parameter int          IDXW      = 2,
    parameter logic [7:0]  BASE_ADDR = 8'h21,
    parameter logic [7:0]  INIT_ADDR = 8'h00,
    parameter logic [7:0]  INIT_DATA = 8'h10,
    parameter int          PERIOD    = 100000,
    parameter int          TIMEOUT   = 63
) (
    input  logic                  clk,
    input  logic                  reset_count,
    input  logic                  wr_req,
    input  logic [IDXW-1:0]       wr_index,
    input  logic [7:0]            wr_data,
    output logic                  wr_ack,
    output logic                  gen_en,
    output logic                  gen_wr,
    input  logic                  gen_done,
    input  logic                  gen_rd_n,
    output logic [7:0]            bus_addr,
    output logic [7:0]            bus_data_out,
    input  logic [7:0]            bus_data_in,
    output logic [8*N_REGS-1:0]   time_bank,
    output logic                  bank_valid,
    output logic                  busy,
    output logic                  err
);

    // Counter and index widths, guarded so degenerate parameters stay legal
    localparam int KW  = (N_REGS  > 1) ? $clog2(N_REGS)  : 1;
    localparam int TCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int PCW = (PERIOD  > 1) ? $clog2(PERIOD)  : 1;

    localparam logic [KW-1:0]  K_LAST      = KW'(N_REGS - 1);
    localparam logic [TCW-1:0] TMO_LAST    = TCW'(TIMEOUT - 1);
    localparam logic [PCW-1:0] PERIOD_LAST = PCW'(PERIOD - 1);

    typedef enum logic [2:0] {
        ST_INIT        = 3'd0,
        ST_ISSUE       = 3'd1,
        ST_SWEEP_ISSUE = 3'd2,
        ST_USER_ISSUE  = 3'd3,
        ST_WAIT_DONE   = 3'd4,
        ST_COMMIT      = 3'd5,
        ST_WAIT_PERIOD = 3'd6
    } state_t;

    // Kind of the transaction currently owned by the generator
    typedef enum logic [1:0] {
        TX_INIT  = 2'd0,
        TX_SWEEP = 2'd1,
        TX_USER  = 2'd2
    } txn_t;

    state_t               state_q,      state_d;
    txn_t                 txn_q,        txn_d;
    logic [KW-1:0]        k_q,          k_d;
    logic [TCW-1:0]       tmo_q,        tmo_d;
    logic [PCW-1:0]       period_q,     period_d;
    logic [8*N_REGS-1:0]  shadow_q,     shadow_d;
    logic [8*N_REGS-1:0]  time_bank_q,  time_bank_d;
    logic                 bank_valid_q, bank_valid_d;
    logic                 busy_q,       busy_d;
    logic                 err_q,        err_d;
    logic                 wr_ack_q,     wr_ack_d;
    logic                 gen_en_q,     gen_en_d;
    logic                 gen_wr_q,     gen_wr_d;
    logic [7:0]           bus_addr_q,   bus_addr_d;
    logic [7:0]           bus_data_q,   bus_data_d;

    // Shared "start sweep read k" request raised from several states
    logic                 sweep_go;
    logic [KW-1:0]        sweep_k;

    // Next-state, next-output and datapath update for the whole sequencer
    always_comb begin
        state_d      = state_q;
        txn_d        = txn_q;
        k_d          = k_q;
        tmo_d        = tmo_q;
        period_d     = period_q;
        shadow_d     = shadow_q;
        time_bank_d  = time_bank_q;
        bank_valid_d = bank_valid_q;
        err_d        = err_q;
        gen_wr_d     = gen_wr_q;
        bus_addr_d   = bus_addr_q;
        bus_data_d   = bus_data_q;
        gen_en_d     = 1'b0;
        wr_ack_d     = 1'b0;
        sweep_go     = 1'b0;
        sweep_k      = '0;

        case (state_q)
            ST_INIT: begin
                state_d    = ST_ISSUE;
                txn_d      = TX_INIT;
                bus_addr_d = INIT_ADDR;
                bus_data_d = INIT_DATA;
                gen_wr_d   = 1'b1;
                gen_en_d   = 1'b1;
                tmo_d      = '0;
            end

            ST_ISSUE, ST_SWEEP_ISSUE, ST_USER_ISSUE: begin
                state_d = ST_WAIT_DONE;
            end

            ST_WAIT_DONE: begin
                // Keep overwriting so the last strobed sample before done wins
                if (txn_q == TX_SWEEP && !gen_rd_n) begin
                    shadow_d[8*int'(k_q) +: 8] = bus_data_in;
                end
                if (gen_done) begin
                    case (txn_q)
                        TX_SWEEP: begin
                            if (k_q == K_LAST) begin
                                state_d = ST_COMMIT;
                            end else begin
                                sweep_go = 1'b1;
                                sweep_k  = k_q + KW'(1);
                            end
                        end
                        TX_USER: begin
                            wr_ack_d = 1'b1;
                            sweep_go = 1'b1;
                        end
                        default: begin
                            sweep_go = 1'b1;
                        end
                    endcase
                end else if (tmo_q == TMO_LAST) begin
                    // Abandon the whole sweep: partial data must never reach time_bank
                    err_d    = 1'b1;
                    shadow_d = '0;
                    period_d = '0;
                    state_d  = ST_WAIT_PERIOD;
                end else begin
                    tmo_d = tmo_q + TCW'(1);
                end
            end

            ST_COMMIT: begin
                time_bank_d  = shadow_q;
                bank_valid_d = 1'b1;
                period_d     = '0;
                state_d      = ST_WAIT_PERIOD;
            end

            ST_WAIT_PERIOD: begin
                if (wr_req) begin
                    if (int'(wr_index) >= N_REGS) begin
                        // Out-of-range target: acknowledge without touching the bus
                        wr_ack_d = 1'b1;
                        sweep_go = 1'b1;
                    end else begin
                        state_d    = ST_USER_ISSUE;
                        txn_d      = TX_USER;
                        bus_addr_d = BASE_ADDR + 8'(wr_index);
                        bus_data_d = wr_data;
                        gen_wr_d   = 1'b1;
                        gen_en_d   = 1'b1;
                        tmo_d      = '0;
                    end
                end else if (period_q == PERIOD_LAST) begin
                    sweep_go = 1'b1;
                end else begin
                    period_d = period_q + PCW'(1);
                end
            end

            default: begin
                state_d = ST_INIT;
            end
        endcase

        if (sweep_go) begin
            state_d    = ST_SWEEP_ISSUE;
            txn_d      = TX_SWEEP;
            k_d        = sweep_k;
            bus_addr_d = BASE_ADDR + 8'(sweep_k);
            bus_data_d = 8'h00;
            gen_wr_d   = 1'b0;
            gen_en_d   = 1'b1;
            tmo_d      = '0;
        end

        busy_d = (state_d != ST_WAIT_PERIOD);
    end

    // State and registered outputs; asynchronous reset shared with the generator
    always_ff @(posedge clk or posedge reset_count) begin
        if (reset_count) begin
            state_q      <= ST_INIT;
            txn_q        <= TX_INIT;
            k_q          <= '0;
            tmo_q        <= '0;
            period_q     <= '0;
            shadow_q     <= '0;
            time_bank_q  <= '0;
            bank_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
            wr_ack_q     <= 1'b0;
            gen_en_q     <= 1'b0;
            gen_wr_q     <= 1'b0;
            bus_addr_q   <= 8'h00;
            bus_data_q   <= 8'h00;
        end else begin
            state_q      <= state_d;
            txn_q        <= txn_d;
            k_q          <= k_d;
            tmo_q        <= tmo_d;
            period_q     <= period_d;
            shadow_q     <= shadow_d;
            time_bank_q  <= time_bank_d;
            bank_valid_q <= bank_valid_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
            wr_ack_q     <= wr_ack_d;
            gen_en_q     <= gen_en_d;
            gen_wr_q     <= gen_wr_d;
            bus_addr_q   <= bus_addr_d;
            bus_data_q   <= bus_data_d;
        end
    end

    assign wr_ack       = wr_ack_q;
    assign gen_en       = gen_en_q;
    assign gen_wr       = gen_wr_q;
    assign bus_addr     = bus_addr_q;
    assign bus_data_out = bus_data_q;
    assign time_bank    = time_bank_q;
    assign bank_valid   = bank_valid_q;
    assign busy         = busy_q;
    assign err          = err_q;

endmodule
`default_nettype wire

// File: tb/tb_rtc_transaction_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_rtc_transaction_sequencer
// Description : Self-checking bench with a behavioural RTC generator model and
//               transaction / time-bank scoreboards.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rtc_transaction_sequencer;

    localparam int         N_REGS    = 4;
    localparam int         IDXW      = 2;
    localparam int         PERIOD    = 10;
    localparam int         TIMEOUT   = 63;
    localparam int         DONE_DLY  = 21;
    localparam logic [7:0] BASE_ADDR = 8'h21;
    localparam logic [7:0] INIT_ADDR = 8'h00;
    localparam logic [7:0] INIT_DATA = 8'h10;

    logic                clk = 1'b0;
    logic                reset_count = 1'b0;
    logic                wr_req = 1'b0;
    logic [IDXW-1:0]     wr_index = '0;
    logic [7:0]          wr_data = 8'h00;
    logic                gen_done = 1'b0;
    logic                gen_rd_n = 1'b1;
    logic [7:0]          bus_data_in = 8'h00;
    logic                wr_ack, gen_en, gen_wr, bank_valid, busy, err;
    logic [7:0]          bus_addr, bus_data_out;
    logic [8*N_REGS-1:0] time_bank;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Scoreboards: {wr, addr, data} per transaction and committed banks
    logic [16:0] exp_txn  [$];
    logic [31:0] exp_bank [$];

    // Generator model state
    logic [7:0] tbl [N_REGS] = '{8'h30, 8'h45, 8'h12, 8'h07};
    logic [7:0] exp_shadow [N_REGS];
    bit         active = 0, cur_rd = 0, cur_sup = 0, sup_en = 0;
    int         cnt = 0, cur_k = 0, sup_k = 0, sup_cyc = 0;
    logic [7:0] cur_val = 8'h00, sweep_off = 8'h00, sweep_base = 8'h00;
    int         sweep_starts = 0, last_sweep_cyc = 0, prev_sweep_cyc = 0;
    logic [31:0] last_bank = '0;

    rtc_transaction_sequencer #(
        .N_REGS(N_REGS), .IDXW(IDXW), .BASE_ADDR(BASE_ADDR), .INIT_ADDR(INIT_ADDR),
        .INIT_DATA(INIT_DATA), .PERIOD(PERIOD), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset_count(reset_count), .wr_req(wr_req), .wr_index(wr_index),
        .wr_data(wr_data), .wr_ack(wr_ack), .gen_en(gen_en), .gen_wr(gen_wr),
        .gen_done(gen_done), .gen_rd_n(gen_rd_n), .bus_addr(bus_addr),
        .bus_data_out(bus_data_out), .bus_data_in(bus_data_in), .time_bank(time_bank),
        .bank_valid(bank_valid), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Generator model: start on gen_en, read strobe window, done DONE_DLY cycles later
    always @(negedge clk) begin
        logic [16:0] e;
        logic [31:0] b;
        if (reset_count) begin
            active = 0; cur_sup = 0; gen_done = 1'b0; gen_rd_n = 1'b1; bus_data_in = 8'h00;
        end else begin
            gen_done = 1'b0;
            if (gen_en === 1'b1) begin
                total++;
                if (exp_txn.size() == 0) begin
                    bad++;
                    $display("FAIL txn_unexpected: got wr=%0b addr=%02h data=%02h, required no transaction",
                             gen_wr, bus_addr, bus_data_out);
                end else begin
                    e = exp_txn.pop_front();
                    if (gen_wr !== e[16] || bus_addr !== e[15:8] || (e[16] && bus_data_out !== e[7:0])) begin
                        bad++;
                        $display("FAIL txn_order: got wr=%0b addr=%02h data=%02h, required wr=%0b addr=%02h data=%02h",
                                 gen_wr, bus_addr, bus_data_out, e[16], e[15:8], e[7:0]);
                    end
                end
                active = 1; cnt = 0;
                cur_rd = (gen_wr === 1'b0);
                cur_k  = int'(bus_addr - BASE_ADDR);
                if (cur_rd && cur_k == 0) begin
                    sweep_base = sweep_off;
                    sweep_off  = sweep_off + 8'h01;
                    prev_sweep_cyc = last_sweep_cyc;
                    last_sweep_cyc = cyc;
                    sweep_starts++;
                end
                cur_val = (cur_k < N_REGS) ? tbl[cur_k] + sweep_base : 8'h00;
                cur_sup = sup_en && cur_rd && (cur_k == sup_k);
                if (cur_sup) begin
                    sup_en  = 0;
                    sup_cyc = cyc;
                end
            end else if (active) begin
                cnt++;
                gen_rd_n    = !(cur_rd && cnt >= 10 && cnt <= 18);
                bus_data_in = (cnt >= 10 && cnt <= 14) ? ~cur_val :
                              (cnt >= 15 && cnt <= 18) ? cur_val : 8'hEE;
                if (cnt == DONE_DLY) begin
                    active = 0;
                    if (!cur_sup) begin
                        gen_done = 1'b1;
                        if (cur_rd && cur_k < N_REGS) begin
                            exp_shadow[cur_k] = cur_val;
                            if (cur_k == N_REGS - 1) begin
                                for (int k = 0; k < N_REGS; k++) b[8*k +: 8] = exp_shadow[k];
                                exp_bank.push_back(b);
                            end
                        end
                    end
                end
            end
        end
    end

    // Time-bank monitor: every change must match the next completed sweep
    always @(negedge clk) begin
        logic [31:0] eb;
        if (reset_count) begin
            last_bank = '0;
        end else if (time_bank !== last_bank) begin
            total++;
            if (exp_bank.size() == 0) begin
                bad++;
                $display("FAIL bank_unexpected: got %08h, required no update", time_bank);
            end else begin
                eb = exp_bank.pop_front();
                if (time_bank !== eb || bank_valid !== 1'b1) begin
                    bad++;
                    $display("FAIL bank_value: got %08h valid=%0b, required %08h valid=1",
                             time_bank, bank_valid, eb);
                end
            end
            last_bank = time_bank;
        end
    end

    task automatic push_sweep();
        for (int k = 0; k < N_REGS; k++) exp_txn.push_back({1'b0, BASE_ADDR + 8'(k), 8'h00});
    endtask

    task automatic wait_queue_le(input int n, input string name);
        int c = 0;
        while (exp_txn.size() > n && c < 2000) begin
            @(negedge clk);
            c++;
        end
        if (c >= 2000) begin
            total++; bad++;
            $display("FAIL %s_queue_wait: got %0d pending, required <= %0d", name, exp_txn.size(), n);
        end
    endtask

    task automatic wait_idle(input string name);
        int c = 0;
        wait_queue_le(0, name);
        @(negedge clk);
        while (busy !== 1'b0 && c < 2000) begin
            @(negedge clk);
            c++;
        end
        if (c >= 2000) begin
            total++; bad++;
            $display("FAIL %s_idle_wait: got busy=%0b, required 0", name, busy);
        end
    endtask

    task automatic check_outputs_zero(input string name);
        total++;
        if ({gen_en, gen_wr, wr_ack, bank_valid, busy, err} !== 6'b0 ||
            bus_addr !== 8'h00 || bus_data_out !== 8'h00 || time_bank !== 32'h0) begin
            bad++;
            $display("FAIL %s: got en=%0b wr=%0b ack=%0b valid=%0b busy=%0b err=%0b addr=%02h data=%02h bank=%08h, required all 0",
                     name, gen_en, gen_wr, wr_ack, bank_valid, busy, err, bus_addr, bus_data_out, time_bank);
        end
    endtask

    task automatic test_reset();
        #1 reset_count = 1'b1;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset_outputs");
        exp_txn.push_back({1'b1, INIT_ADDR, INIT_DATA});
        push_sweep();
        #2 reset_count = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL busy_after_reset: got %0b, required 1", busy);
        end
    endtask

    task automatic test_first_commit();
        int c = 0;
        while (bank_valid !== 1'b1 && c < 400) begin
            @(negedge clk);
            c++;
        end
        total++;
        if (time_bank !== 32'h07124530 || bank_valid !== 1'b1) begin
            bad++;
            $display("FAIL first_bank: got %08h valid=%0b, required 07124530 valid=1", time_bank, bank_valid);
        end
        total++;
        if (busy !== 1'b0 || err !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_commit: got busy=%0b err=%0b, required busy=0 err=0", busy, err);
        end
    endtask

    task automatic test_user_write_deferred();
        int c = 0;
        int ack_cyc;
        push_sweep();
        wait_queue_le(N_REGS - 1, "user_sweep_start");
        @(negedge clk);
        wr_index = 2'd1; wr_data = 8'h59; wr_req = 1'b1;
        exp_txn.push_back({1'b1, 8'h22, 8'h59});
        push_sweep();
        while (wr_ack !== 1'b1 && c < 400) begin
            @(negedge clk);
            c++;
        end
        ack_cyc = cyc;
        wr_req = 1'b0;
        total++;
        if (c >= 400) begin
            bad++;
            $display("FAIL user_ack_wait: got no wr_ack, required a pulse");
        end
        @(negedge clk);
        total++;
        if (wr_ack !== 1'b0) begin
            bad++;
            $display("FAIL user_ack_pulse: got wr_ack=%0b, required 0", wr_ack);
        end
        total++;
        if (last_sweep_cyc !== ack_cyc) begin
            bad++;
            $display("FAIL user_sweep_follow: got sweep start cycle %0d, required %0d", last_sweep_cyc, ack_cyc);
        end
        wait_idle("user");
    endtask

    task automatic test_timeout();
        int c = 0;
        logic [31:0] saved;
        saved = time_bank;
        sup_k = 2; sup_en = 1;
        for (int k = 0; k < 3; k++) exp_txn.push_back({1'b0, BASE_ADDR + 8'(k), 8'h00});
        push_sweep();
        while (err !== 1'b1 && c < 600) begin
            @(negedge clk);
            c++;
        end
        total++;
        if (err !== 1'b1 || (cyc - sup_cyc) < TIMEOUT || (cyc - sup_cyc) > TIMEOUT + 2) begin
            bad++;
            $display("FAIL timeout_err: got err=%0b after %0d cycles, required err=1 after %0d..%0d",
                     err, cyc - sup_cyc, TIMEOUT, TIMEOUT + 2);
        end
        total++;
        if (time_bank !== saved || bank_valid !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL timeout_bank: got %08h valid=%0b busy=%0b, required %08h valid=1 busy=0",
                     time_bank, bank_valid, busy, saved);
        end
        wait_idle("timeout");
        total++;
        if (err !== 1'b1) begin
            bad++;
            $display("FAIL err_sticky: got %0b, required 1", err);
        end
    endtask

    task automatic test_idle_write();
        int c = 0;
        @(negedge clk);
        wr_index = 2'd3; wr_data = 8'hA5; wr_req = 1'b1;
        exp_txn.push_back({1'b1, BASE_ADDR + 8'd3, 8'hA5});
        push_sweep();
        while (wr_ack !== 1'b1 && c < 400) begin
            @(negedge clk);
            c++;
        end
        wr_req = 1'b0;
        total++;
        if (c >= 400) begin
            bad++;
            $display("FAIL idle_ack_wait: got no wr_ack, required a pulse");
        end
        wait_idle("idle_write");
    endtask

    task automatic test_reset_mid();
        push_sweep();
        wait_queue_le(N_REGS - 1, "midreset_start");
        repeat (5) @(negedge clk);
        #2 reset_count = 1'b1;
        #1 check_outputs_zero("midreset_outputs");
        exp_txn.delete();
        exp_bank.delete();
        repeat (2) @(negedge clk);
        exp_txn.push_back({1'b1, INIT_ADDR, INIT_DATA});
        push_sweep();
        #2 reset_count = 1'b0;
        wait_idle("midreset");
        total++;
        if (bank_valid !== 1'b1 || err !== 1'b0) begin
            bad++;
            $display("FAIL midreset_recover: got valid=%0b err=%0b, required valid=1 err=0", bank_valid, err);
        end
    endtask

    task automatic test_back_to_back();
        int c = 0;
        int n0;
        n0 = sweep_starts;
        push_sweep();
        push_sweep();
        while (sweep_starts < n0 + 2 && c < 600) begin
            @(negedge clk);
            c++;
        end
        total++;
        if (last_sweep_cyc - prev_sweep_cyc != 4 * (DONE_DLY + 1) + 1 + PERIOD) begin
            bad++;
            $display("FAIL sweep_spacing: got %0d cycles, required %0d",
                     last_sweep_cyc - prev_sweep_cyc, 4 * (DONE_DLY + 1) + 1 + PERIOD);
        end
        wait_idle("spacing");
    endtask

    initial begin
        test_reset();
        test_first_commit();
        test_user_write_deferred();
        test_timeout();
        test_idle_write();
        test_reset_mid();
        test_back_to_back();
        repeat (3) @(negedge clk);
        total++;
        if (exp_txn.size() != 0 || exp_bank.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d txn / %0d bank pending, required 0 / 0",
                     exp_txn.size(), exp_bank.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
